// File: rtl/key_debounce_pkg.sv
// Shared types and elaboration-time helpers for the key debounce block.
package key_debounce_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } key_state_e;

  // Converts a duration in milliseconds into clock cycles
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq_hz,
                                               input int unsigned ms);
    return clk_freq_hz / 1000 * ms;
  endfunction

  // Bits needed for a counter that must hold max_count itself; never narrower than 1
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, polarity normalisation, debounce FSM and,
// when KEY_LONGPRESS_EN is defined, a long-press counter. Without the macro key_long_o is 0.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEB_CNT    = 4,
`ifdef KEY_LONGPRESS_EN
  parameter int unsigned LONG_CNT   = 10,
`endif
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_long_o
);

  localparam int unsigned DebW = cnt_width(DEB_CNT);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CNT);
  // Raw level meaning "released"; the synchroniser resets to it so reset looks idle
  localparam logic RawReleased = ACTIVE_LOW;

  logic [1:0]      sync_q;
  logic            pressed;
  key_state_e      state_q;
  logic [DebW-1:0] cnt_q;
  logic            level_q;
  logic            press_q;
  logic            release_q;

  // Two-flop synchroniser for the asynchronous raw level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RawReleased}};
    end else begin
      sync_q <= {sync_q[0], key_raw_i};
    end
  end

  // 1 = pressed, regardless of board polarity
  assign pressed = sync_q[1] ^ RawReleased;

  // Debounce FSM with registered level and single-cycle event pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pressed) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!pressed) begin
            // Bounce: back to released, no event
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == DebMax) begin
            state_q <= StHeld;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DebW'(1);
          end
        end
        StHeld: begin
          if (!pressed) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          if (pressed) begin
            // Bounce: back to held, no event
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (cnt_q == DebMax) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DebW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned LongW = cnt_width(LONG_CNT);
  localparam logic [LongW-1:0] LongMax = LongW'(LONG_CNT);
  localparam logic [LongW-1:0] LongPre = LongW'(LONG_CNT - 1);

  logic [LongW-1:0] long_cnt_q;
  logic             long_q;

  // Long-press timer: counts held cycles from the press pulse, saturates, pulses once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == StHeld && pressed) begin
        if (long_cnt_q != LongMax) begin
          long_cnt_q <= long_cnt_q + LongW'(1);
          long_q     <= (long_cnt_q == LongPre);
        end
      end else begin
        long_cnt_q <= '0;
      end
    end
  end

  assign key_long_o = long_q;
`else
  assign key_long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Key/switch input conditioning: per-channel synchronise, debounce, press/release pulses.
// Optional long-press pulse built only when KEY_LONGPRESS_EN is defined.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS      = 5,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] Key_Raw,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release,
  output logic [N_KEYS-1:0] Key_Long
);

  localparam int unsigned DebCnt = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
`ifdef KEY_LONGPRESS_EN
  localparam int unsigned LongCnt = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CNT    (DebCnt),
`ifdef KEY_LONGPRESS_EN
      .LONG_CNT   (LongCnt),
`endif
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk_i         (CLK),
      .rst_ni        (RSTn),
      .key_raw_i     (Key_Raw[i]),
      .key_level_o   (Key_Level[i]),
      .key_press_o   (Key_Press[i]),
      .key_release_o (Key_Release[i]),
      .key_long_o    (Key_Long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (DEB_CNT=4, LONG_CNT=10, active-low keys).
module tb_key_debounce;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [4:0] Key_Raw;
  logic [4:0] Key_Level;
  logic [4:0] Key_Press;
  logic [4:0] Key_Release;
  logic [4:0] Key_Long;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  key_debounce #(
    .N_KEYS      (5),
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (10),
    .ACTIVE_LOW  (1)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_Raw     (Key_Raw),
    .Key_Level   (Key_Level),
    .Key_Press   (Key_Press),
    .Key_Release (Key_Release),
    .Key_Long    (Key_Long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check_long_idle(input string tag);
    check(tag, Key_Long, 5'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    RSTn    = 1'b1;
    Key_Raw = 5'b11111;
    #2 RSTn = 1'b0;
    tick();
    tick();
    check("rst_level", Key_Level, 5'b0);
    check("rst_press", Key_Press, 5'b0);
    check("rst_release", Key_Release, 5'b0);
    check("rst_long", Key_Long, 5'b0);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_press", Key_Press, 5'b0);
    end

    // Clean press on ch0: pulse in cycle 7, long pulse 10 cycles later when enabled
    Key_Raw[0] = 1'b0;
    for (int i = 0; i < 21; i++) begin
      tick();
      check("press0", Key_Press[0], i == 7);
      check("level0", Key_Level[0], i >= 7);
      check("press0_norel", Key_Release[0], 1'b0);
`ifdef KEY_LONGPRESS_EN
      check("long0", Key_Long[0], i == 17);
`else
      check_long_idle("long_off");
`endif
    end

    // 3-cycle release glitch on ch0 must not release
    Key_Raw[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) Key_Raw[0] = 1'b0;
      tick();
      check("glitch_rel0", Key_Release[0], 1'b0);
      check("glitch_press0", Key_Press[0], 1'b0);
      check("glitch_level0", Key_Level[0], 1'b1);
      check_long_idle("glitch_long");
    end

    // Clean release on ch0
    Key_Raw[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rel0", Key_Release[0], i == 7);
      check("rel_level0", Key_Level[0], i < 7);
      check("rel_press0", Key_Press[0], 1'b0);
      check_long_idle("rel_long");
    end

    // Bounce on ch1: low 2, high 1, low 2, high 1, then low
    pat = 6'b100100;
    for (int j = 0; j < 6; j++) begin
      Key_Raw[1] = pat[j];
      tick();
      check("bounce_nopress1", Key_Press[1], 1'b0);
      check("bounce_level1", Key_Level[1], 1'b0);
    end
    Key_Raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("bounce_press1", Key_Press[1], i == 7);
      check("bounce_lvl1", Key_Level[1], i >= 7);
    end

    // Simultaneous press on ch2 and ch3
    Key_Raw[3:2] = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("sim_press32", Key_Press[3:2], (i == 7) ? 2'b11 : 2'b00);
      check("sim_press10", Key_Press[1:0], 2'b00);
      check("sim_level32", Key_Level[3:2], (i >= 7) ? 2'b11 : 2'b00);
    end

    // Reset during a ch4 press; held keys are pressed anew after reset
    Key_Raw[4] = 1'b0;
    tick();
    tick();
    RSTn = 1'b0;
    #1;
    check("midrst_level", Key_Level, 5'b0);
    check("midrst_press", Key_Press, 5'b0);
    check("midrst_release", Key_Release, 5'b0);
    check("midrst_long", Key_Long, 5'b0);
    tick();
    tick();
    check("midrst_level_hold", Key_Level, 5'b0);
    RSTn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("postrst_press", Key_Press, (i == 7) ? 5'b11110 : 5'b00000);
      check("postrst_level", Key_Level, (i >= 7) ? 5'b11110 : 5'b00000);
      check("postrst_release", Key_Release, 5'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
